// File: rtl/uart_tx_top_if.sv
// Serial transmit board interface: switch/button inputs, line and display outputs.
// Latency: n/a (wires only).
// Backpressure: none; presses arriving while a frame is in flight are dropped by the slave.
//
// Ports:
//   i_Data  8  byte to send (slide switches)
//   i_Send  1  send push button, active-low
//   o_Tx    1  serial line, idle high
//   o_fBusy 1  frame in progress
//   o_fDone 1  one-cycle pulse at end of frame
//   o_FND0  7  segments, low nibble of last byte sent
//   o_FND1  7  segments, high nibble of last byte sent
interface uart_tx_top_if;
   logic [7:0] i_Data;
   logic       i_Send;
   logic       o_Tx;
   logic       o_fBusy;
   logic       o_fDone;
   logic [6:0] o_FND0;
   logic [6:0] o_FND1;

   modport master (
      output i_Data, i_Send,
      input  o_Tx, o_fBusy, o_fDone, o_FND0, o_FND1
   );

   modport slave (
      input  i_Data, i_Send,
      output o_Tx, o_fBusy, o_fDone, o_FND0, o_FND1
   );
endinterface

// File: rtl/uart_tx_top.sv
// UART transmitter top: button press sends the switch byte as one 8N1 (8E1) frame, LSB first.
// Latency: o_Tx falls 3 cycles after i_Send is first sampled low; frame is 10 (11) bit times.
// Backpressure: none; presses while a frame is in progress are dropped, never queued.
//
// Ports: i_Clk clock, i_Rst async active-low reset, bus (uart_tx_top_if.slave):
//   i_Data/i_Send in, o_Tx/o_fBusy/o_fDone/o_FND0/o_FND1 out.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1).

// Hex digit to seven segments, active-high, bit order {g,f,e,d,c,b,a}.
module FND (
   input  logic [3:0] i_Num,
   output logic [6:0] o_Seg
);
   always_comb begin
      o_Seg = 7'h00;
      case (i_Num)
         4'h0: o_Seg = 7'h3F;
         4'h1: o_Seg = 7'h06;
         4'h2: o_Seg = 7'h5B;
         4'h3: o_Seg = 7'h4F;
         4'h4: o_Seg = 7'h66;
         4'h5: o_Seg = 7'h6D;
         4'h6: o_Seg = 7'h7D;
         4'h7: o_Seg = 7'h07;
         4'h8: o_Seg = 7'h7F;
         4'h9: o_Seg = 7'h6F;
         4'hA: o_Seg = 7'h77;
         4'hB: o_Seg = 7'h7C;
         4'hC: o_Seg = 7'h39;
         4'hD: o_Seg = 7'h5E;
         4'hE: o_Seg = 7'h79;
         default: o_Seg = 7'h71;
      endcase
   end
endmodule

module uart_tx_top #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   uart_tx_top_if.slave  bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   // Button synchronizer; the third flop gives the previous level for edge detection.
   logic send_s1, send_s2, send_s3, press_q;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         send_s1 <= 1'b1;
         send_s2 <= 1'b1;
         send_s3 <= 1'b1;
         press_q <= 1'b0;
      end else begin
         send_s1 <= bus.i_Send;
         send_s2 <= send_s1;
         send_s3 <= send_s2;
         press_q <= send_s3 & ~send_s2;   // falling edge only, so a held button fires once
      end
   end

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    disp_q, disp_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // State register; outputs are registered alongside so they change on the same edge.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         disp_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         disp_q  <= disp_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic. The switches are sampled only in the press cycle; they are
   // static by then, so no synchronizer is used on i_Data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      disp_d  = disp_q;
      if (state_q != IDLE)
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (press_q) begin
               shreg_d = bus.i_Data;
               disp_d  = bus.i_Data;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP:   if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic, decoded from the upcoming state so it lands in the output flops.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != IDLE);
      done_d = (state_q == STOP) && (state_d == IDLE);
      case (state_d)
         START:  tx_d = 1'b0;
         DATA:   tx_d = shreg_d[idx_d];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_d = ^shreg_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   assign bus.o_Tx    = tx_q;
   assign bus.o_fBusy = busy_q;
   assign bus.o_fDone = done_q;

   FND u_fnd0 (.i_Num(disp_q[3:0]), .o_Seg(bus.o_FND0));
   FND u_fnd1 (.i_Num(disp_q[7:4]), .o_Seg(bus.o_FND1));
endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: random and directed frames against a bit-slot line model.
// Latency: checks the 3-cycle press-to-start-bit delay and the full frame length.
// Backpressure: checks that held and mid-frame presses are dropped.
module tb_uart_tx_top;
   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic i_Clk = 1'b0;
   logic i_Rst;
   always #5 i_Clk = ~i_Clk;

   uart_tx_top_if bus();

   uart_tx_top #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
         4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
         4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
         4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Line level for bit slot 'slot' of the frame carrying byte d.
   function automatic logic frame_bit(input logic [7:0] d, input int slot);
      int ones;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return (d >> (slot - 1)) & 8'h01;
`ifdef UART_TX_PARITY_EN
      if (slot == 9) begin
         ones = 0;
         for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
         return (ones % 2) == 1;
      end
`endif
      return 1'b1;
   endfunction

   task automatic idle_watch(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge i_Clk);
         check_val("idle_tx", bus.o_Tx, 1);
         check_val("idle_busy", bus.o_fBusy, 0);
         check_val("idle_done", bus.o_fDone, 0);
      end
   endtask

   // Called at a negedge with i_Send high; returns at the negedge of the o_fDone cycle.
   task automatic send_frame(input logic [7:0] d, input int hold, input bit mid_press,
                             input bit scramble);
      bus.i_Data = d;
      bus.i_Send = 1'b0;
      for (int n = 0; n <= 3 + FRAME; n++) begin
         @(negedge i_Clk);
         if (n < 3) begin
            check_val("pre_tx", bus.o_Tx, 1);
            check_val("pre_busy", bus.o_fBusy, 0);
            check_val("pre_done", bus.o_fDone, 0);
         end else if (n < 3 + FRAME) begin
            check_val($sformatf("tx_slot%0d", (n - 3) / CPB), bus.o_Tx, frame_bit(d, (n - 3) / CPB));
            check_val("frm_busy", bus.o_fBusy, 1);
            check_val("frm_done", bus.o_fDone, 0);
         end else begin
            check_val("end_done", bus.o_fDone, 1);
            check_val("end_busy", bus.o_fBusy, 0);
            check_val("end_tx", bus.o_Tx, 1);
         end
         if (n == 3 || n == 3 + FRAME) begin
            check_val("fnd0", bus.o_FND0, seg7(d[3:0]));
            check_val("fnd1", bus.o_FND1, seg7(d[7:4]));
         end
         if (n == hold) bus.i_Send = 1'b1;
         if (mid_press && n == 40) begin
            bus.i_Data = 8'h3C;
            bus.i_Send = 1'b0;
         end
         if (mid_press && n == 45) bus.i_Send = 1'b1;
         if (scramble && n == 20) bus.i_Data = 8'($urandom);
      end
   endtask

   initial begin
      logic [7:0] rd;
      i_Rst      = 1'b0;
      bus.i_Send = 1'b1;
      bus.i_Data = 8'h00;

      // Reset, with button activity that must not start a frame.
      repeat (3) @(negedge i_Clk);
      bus.i_Send = 1'b0;
      repeat (4) @(negedge i_Clk);
      bus.i_Send = 1'b1;
      repeat (2) @(negedge i_Clk);
      check_val("rst_tx", bus.o_Tx, 1);
      check_val("rst_busy", bus.o_fBusy, 0);
      check_val("rst_done", bus.o_fDone, 0);
      check_val("rst_fnd0", bus.o_FND0, seg7(4'h0));
      check_val("rst_fnd1", bus.o_FND1, seg7(4'h0));
      i_Rst = 1'b1;
      idle_watch(20);

      // Single send.
      send_frame(8'hA5, 5, 1'b0, 1'b0);
      idle_watch(5);

      // Button held 300 cycles: one frame only.
      send_frame(8'hA5, 400, 1'b0, 1'b0);
      idle_watch(197);
      bus.i_Send = 1'b1;
      idle_watch(30);

      // Mid-frame press with new data is dropped.
      send_frame(8'hA5, 5, 1'b1, 1'b0);
      idle_watch(40);

      // Back-to-back: second press in the first IDLE cycle.
      send_frame(8'h5A, 5, 1'b0, 1'b0);
      send_frame(8'h00, 5, 1'b0, 1'b0);
      idle_watch(5);

      // Reset during data bit 4 (a 0 bit, so the async return to high is visible).
      bus.i_Data = 8'hC3;
      bus.i_Send = 1'b0;
      for (int n = 0; n <= 55; n++) begin
         @(negedge i_Clk);
         if (n == 5) bus.i_Send = 1'b1;
      end
      check_val("bit4_low", bus.o_Tx, 0);
      i_Rst = 1'b0;
      #1;
      check_val("arst_tx", bus.o_Tx, 1);
      check_val("arst_busy", bus.o_fBusy, 0);
      check_val("arst_done", bus.o_fDone, 0);
      check_val("arst_fnd0", bus.o_FND0, seg7(4'h0));
      repeat (3) @(negedge i_Clk);
      i_Rst = 1'b1;
      idle_watch(30);
      send_frame(8'h96, 5, 1'b0, 1'b0);
      idle_watch(3);

      // Parity patterns (plain data bits when parity is not built in).
      send_frame(8'h07, 5, 1'b0, 1'b0);
      idle_watch(3);
      send_frame(8'h03, 5, 1'b0, 1'b0);
      idle_watch(3);

      // Random bytes, holds, gaps and switch changes mid-frame.
      for (int k = 0; k < 24; k++) begin
         rd = 8'($urandom);
         send_frame(rd, $urandom_range(1, 30), 1'b0, 1'b1);
         if ($urandom_range(0, 1) == 1) idle_watch($urandom_range(1, 15));
      end
      idle_watch(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Board-level UART transmitter: on a press of the send button, latches the 8-bit switch value and transmits it as one 8N1 frame (8E1 with parity compiled in), LSB first, on `o_Tx`. The transmitted byte is shown as two hex digits on two seven-segment displays through the existing `FND` decoder. It is the transmit-side counterpart of the board's UART receive/display top and shares its baud rate, so two boards can be wired Tx→Rx.

## Interface
- `CLK_FREQ`, 50_000_000: input clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ/BAUD`, integer division, truncated (434 at defaults); must be ≥ 2.

Ports (reset `i_Rst`, asynchronous, active-low; clock `i_Clk`):
- `i_Clk`  in  1  system clock.
- `i_Rst`  in  1  asynchronous active-low reset.
- `i_Data`  in  8  byte to send (slide switches); asynchronous, sampled only at trigger.
- `i_Send`  in  1  push button, active-low, asynchronous.
- `o_Tx`  out  1  serial line, idle high.
- `o_fBusy`  out  1  high while a frame is in progress.
- `o_fDone`  out  1  one-cycle pulse at end of frame.
- `o_FND0`  out  7  segments for the low nibble of the last byte sent.
- `o_FND1`  out  7  segments for the high nibble of the last byte sent.

## Operation
- `i_Send` passes through a 2-flop synchronizer, then a third flop. Press = third flop 1 and second flop 0 (falling edge), a one-cycle event. Holding the button gives exactly one press.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP. All state, counters and outputs are registered.
  - **IDLE:** `o_Tx`=1. On a press, latch `i_Data` into the shift register and the display register, clear the baud counter, and go to START.
  - **START:** `o_Tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - **DATA:** `o_Tx`=`data[idx]` for `CLKS_PER_BIT` cycles per bit, idx 0..7. After idx 7, go to PARITY or STOP.
  - **PARITY:** `o_Tx`=XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - **STOP:** `o_Tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1. The state/bit advances when the counter equals `CLKS_PER_BIT`-1, and the counter wraps to 0.
- `o_fBusy` = (state ≠ IDLE), registered together with the state.
- Presses while not in IDLE are dropped, not queued. This includes a press in the same cycle the FSM leaves STOP.
- `i_Data` changes during a frame do not affect the frame or the display.
- Display register: 8 bits, nibbles feed two `FND` instances.
- Reset values: `o_Tx`=1, `o_fBusy`=0, `o_fDone`=0, state IDLE, counters 0, display register 0 (both displays show "0"), synchronizer flops 1.
- Reset asserted mid-frame aborts immediately: `o_Tx` returns high asynchronously and no `o_Fdone` pulse is produced.

## Timing
- Latency from `i_Send` first sampled low at edge k to `o_Tx` low: `o_Tx` is low after edge k+3. `o_fBusy` rises on the same edge.
- Frame length: 10×`CLKS_PER_BIT` cycles (11× with parity), from `o_Tx` falling to the FSM entering IDLE.
- `o_fDone` is high for exactly the first IDLE cycle after STOP, coinciding with `o_fBusy` falling.
- `o_FND0`/`o_FND1` update on the edge the frame starts.
- Earliest next frame: a new press recognized in IDLE. No gap is required beyond the stop bit.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present, frame is 8E1, 11 bit times.
- `UART_TX_PARITY_EN` undefined: no PARITY state, frame is 8N1, 10 bit times.
- The receiver must be built with the matching setting.

## Test plan
Benches use `CLK_FREQ`=1_000_000 and `BAUD`=100_000, giving `CLKS_PER_BIT`=10.
- **Reset:** assert `i_Rst`=0 → `o_Tx`=1, `o_fBusy`=0, `o_fDone`=0, both FND show "0"; `i_Send` pulses during reset have no effect.
- **Single send:** `i_Data`=8'hA5, press `i_Send` → `o_Tx` low 3 cycles later. Line carries start 0, then 1,0,1,0,0,1,0,1, then stop 1, 10 cycles each. `o_fDone` pulses once after 100 cycles; FND1 shows "A", FND0 shows "5".
- **Held/busy press:** hold `i_Send` low 300 cycles → exactly one frame. A second press mid-frame with `i_Data`=8'h3C → ignored; frame still carries 8'hA5 and no second frame follows.
- **Back-to-back:** press again in the first IDLE cycle after `o_fDone` with `i_Data`=8'h00 → second frame with 8 zero data bits, stop bit intact, display "00".
- **Reset mid-frame:** assert reset during DATA bit 4 → `o_Tx`=1 immediately, no `o_fDone`. After release, the next press sends a full, correct frame.
- **Parity** (`UART_TX_PARITY_EN` defined): `i_Data`=8'h07 → parity bit 1, frame 110 cycles. `i_Data`=8'h03 → parity bit 0.
